// File: rtl/adc_capture_ctrl.sv
// Capture sequencer for the AD9643 DDR stream datapath (ADC clock domain only).
// Optional feature macro: ADC_CAPTURE_OR_ABORT_EN (overrange aborts capture, adds err_or).
module adc_capture_ctrl #(
  parameter int LEN_W     = 16,
  parameter int DLY_W     = 16,
  parameter int DRAIN_CYC = 4
) (
  input  logic             m_axi_aclk,
  input  logic             m_axi_aresetn,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic             cfg_trig_ext_en,
  input  logic             ext_trig,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [LEN_W-1:0] cfg_length,
  input  logic             s_tvalid_chA,
  input  logic             s_tvalid_chB,
  input  logic [1:0]       adc_or,
  output logic             ddr_data_en,
  output logic             m_tlast_chA,
  output logic             m_tlast_chB,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_o,
  output logic [7:0]       or_events
`ifdef ADC_CAPTURE_OR_ABORT_EN
  ,
  output logic             err_or
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  localparam int                 DRAIN_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
  localparam logic [LEN_W-1:0]   LEN_ONE    = LEN_W'(1);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_a_q, cnt_a_d;
  logic [LEN_W-1:0]   cnt_b_q, cnt_b_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [7:0]         or_cnt_q, or_cnt_d;
  logic               trig_prev_q;
  logic               en_q, en_d;
  logic               done_q, done_d;
`ifdef ADC_CAPTURE_OR_ABORT_EN
  logic               err_q, err_d;
`endif

  logic len_zero, or_hit, beat_a, beat_b, tlast_a, tlast_b, frame_full;

  always_comb begin
    // NOTE: every _d starts from its _q so no branch below can leave a signal unassigned (no latches).
    state_d     = state_q;
    len_d       = len_q;
    dly_d       = dly_q;
    dly_cnt_d   = dly_cnt_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    drain_cnt_d = drain_cnt_q;
    or_cnt_d    = or_cnt_q;
`ifdef ADC_CAPTURE_OR_ABORT_EN
    err_d       = err_q;
`endif
    len_zero    = (len_q == '0);
    or_hit      = |adc_or;
    beat_a      = 1'b0;
    beat_b      = 1'b0;
    tlast_a     = 1'b0;
    tlast_b     = 1'b0;
    frame_full  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A simultaneous stop cancels the start outright.
        if (cfg_start && !cfg_stop) begin
          len_d    = cfg_length;
          dly_d    = cfg_delay;
          cnt_a_d  = '0;
          cnt_b_d  = '0;
          or_cnt_d = '0;
`ifdef ADC_CAPTURE_OR_ABORT_EN
          err_d    = 1'b0;
`endif
          if (cfg_trig_ext_en) begin
            state_d = S_ARMED;
          end else begin
            state_d   = S_DELAY;
            dly_cnt_d = cfg_delay;
          end
        end
      end
      S_ARMED: begin
        if (cfg_stop) begin
          state_d = S_DRAIN;
        end else if (ext_trig && !trig_prev_q) begin
          state_d   = S_DELAY;
          dly_cnt_d = dly_q;
        end
      end
      S_DELAY: begin
        if (cfg_stop)                state_d = S_DRAIN;
        else if (dly_cnt_q == '0)    state_d = S_CAPTURE;
        else                         dly_cnt_d = dly_cnt_q - DLY_W'(1);
      end
      S_CAPTURE: begin
        // A channel that already delivered len beats ignores further valids.
        beat_a  = s_tvalid_chA && (len_zero || (cnt_a_q != len_q));
        beat_b  = s_tvalid_chB && (len_zero || (cnt_b_q != len_q));
        tlast_a = beat_a && !len_zero && (cnt_a_q == len_q - LEN_ONE);
        tlast_b = beat_b && !len_zero && (cnt_b_q == len_q - LEN_ONE);
        if (beat_a) cnt_a_d = cnt_a_q + LEN_ONE;
        if (beat_b) cnt_b_d = cnt_b_q + LEN_ONE;
        if (or_hit && (or_cnt_q != 8'hFF)) or_cnt_d = or_cnt_q + 8'd1;
        frame_full = !len_zero && (cnt_a_d == len_q) && (cnt_b_d == len_q);
        if (cfg_stop || frame_full) state_d = S_DRAIN;
`ifdef ADC_CAPTURE_OR_ABORT_EN
        if (or_hit) begin
          state_d = S_DRAIN;
          err_d   = 1'b1;
        end
`endif
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) state_d = S_DONE;
        else                   drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_DRAIN) && (state_q != S_DRAIN)) drain_cnt_d = DRAIN_LAST;
    en_d   = (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values; reset is sampled on the edge.
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      dly_q       <= '0;
      dly_cnt_q   <= '0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      drain_cnt_q <= '0;
      or_cnt_q    <= '0;
      trig_prev_q <= 1'b0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
`ifdef ADC_CAPTURE_OR_ABORT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      dly_q       <= dly_d;
      dly_cnt_q   <= dly_cnt_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      drain_cnt_q <= drain_cnt_d;
      or_cnt_q    <= or_cnt_d;
      trig_prev_q <= ext_trig;
      en_q        <= en_d;
      done_q      <= done_d;
`ifdef ADC_CAPTURE_OR_ABORT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign ddr_data_en = en_q;
  assign m_tlast_chA = tlast_a;
  assign m_tlast_chB = tlast_b;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign state_o     = state_q;
  assign or_events   = or_cnt_q;
`ifdef ADC_CAPTURE_OR_ABORT_EN
  assign err_or      = err_q;
`endif

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomized bench for adc_capture_ctrl: each frame's timeline is predicted from the stimulus
// arrays (trigger edge, delay, beat counts, stop/overrange) and compared cycle by cycle.
module tb_adc_capture_ctrl;

  localparam int LEN_W     = 16;
  localparam int DLY_W     = 16;
  localparam int DRAIN_CYC = 4;
`ifdef ADC_CAPTURE_OR_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  typedef struct {
    int       len;
    int       dly;
    bit       trig_en;
    int       pa;
    int       pb;
    int       p_or;
    bit [1:0] or_fix;
    int       stop_at;
    bit       trig_pre;
    int       trig_lo;
    int       trig_hi;
    int       rst_at;
    int       maxn;
  } scen_t;

  logic             clk = 1'b0;
  logic             m_axi_aresetn;
  logic             cfg_start, cfg_stop, cfg_trig_ext_en, ext_trig;
  logic [DLY_W-1:0] cfg_delay;
  logic [LEN_W-1:0] cfg_length;
  logic             s_tvalid_chA, s_tvalid_chB;
  logic [1:0]       adc_or;
  logic             ddr_data_en, m_tlast_chA, m_tlast_chB, busy, done;
  logic [2:0]       state_o;
  logic [7:0]       or_events;
`ifdef ADC_CAPTURE_OR_ABORT_EN
  logic             err_or;
`endif

  always #5 clk = ~clk;

  adc_capture_ctrl #(.LEN_W(LEN_W), .DLY_W(DLY_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .m_axi_aclk      (clk),
    .m_axi_aresetn   (m_axi_aresetn),
    .cfg_start       (cfg_start),
    .cfg_stop        (cfg_stop),
    .cfg_trig_ext_en (cfg_trig_ext_en),
    .ext_trig        (ext_trig),
    .cfg_delay       (cfg_delay),
    .cfg_length      (cfg_length),
    .s_tvalid_chA    (s_tvalid_chA),
    .s_tvalid_chB    (s_tvalid_chB),
    .adc_or          (adc_or),
    .ddr_data_en     (ddr_data_en),
    .m_tlast_chA     (m_tlast_chA),
    .m_tlast_chB     (m_tlast_chB),
    .busy            (busy),
    .done            (done),
    .state_o         (state_o),
    .or_events       (or_events)
`ifdef ADC_CAPTURE_OR_ABORT_EN
    ,
    .err_or          (err_or)
`endif
  );

  int    n_vec = 0;
  int    n_miss = 0;
  int    cur_cyc = 0;
  string cur_scen = "reset";
  int    model_or = 0;
  bit    model_err = 1'b0;

  bit       st_va[], st_vb[], st_trig[], st_start[], st_stop[];
  bit [1:0] st_or[];
  int       e_state[], e_or[];
  bit       e_ta[], e_tb[], e_err[];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s.%s @cycle %0d: got %0h, want %0h", cur_scen, tag, cur_cyc, got, exp);
    end
  endtask

  function automatic scen_t dflt();
    scen_t s;
    s.len = 4;        s.dly = 0;       s.trig_en = 1'b0;
    s.pa = 100;       s.pb = 100;      s.p_or = 0;       s.or_fix = 2'b00;
    s.stop_at = -1;   s.trig_pre = 1'b0; s.trig_lo = 0;  s.trig_hi = 1 << 30;
    s.rst_at = -1;    s.maxn = 40;
    return s;
  endfunction

  // Build stimulus, predict the frame from it, then drive and compare every cycle.
  task automatic run_scen(input string name, input scen_t s);
    int n, e, d0, cs, ce, dn, n_run, ca, cb, orc, st;
    bit ab, ba, bb;
    n = s.maxn;
    cur_scen = name;
    st_va = new[n]; st_vb = new[n]; st_trig = new[n]; st_start = new[n]; st_stop = new[n];
    st_or = new[n]; e_state = new[n]; e_or = new[n]; e_ta = new[n]; e_tb = new[n]; e_err = new[n];
    for (int k = 0; k < n; k++) begin
      st_va[k]    = ($urandom_range(99) < s.pa);
      st_vb[k]    = ($urandom_range(99) < s.pb);
      st_or[k]    = ($urandom_range(99) < s.p_or) ?
                    ((s.or_fix != 2'b00) ? s.or_fix : 2'($urandom_range(3, 1))) : 2'b00;
      st_trig[k]  = (k < s.trig_lo) ? s.trig_pre : (k >= s.trig_hi);
      st_start[k] = (k == 0);
      st_stop[k]  = (k == s.stop_at);
      e_ta[k] = 1'b0; e_tb[k] = 1'b0; e_or[k] = 0;
    end

    // Timeline: start at cycle 0, ARMED until the first 0->1 of ext_trig, dly+1 DELAY cycles, then capture.
    e = n;
    for (int k = 1; k < n; k++) if (e == n && st_trig[k] && !st_trig[k-1]) e = k;
    d0  = s.trig_en ? e + 1 : 1;
    cs  = d0 + s.dly + 1;
    orc = 0;
    ab  = 1'b0;
    if (s.stop_at == 0) begin
      ce = 0;
    end else if (s.stop_at >= 1 && s.stop_at < cs) begin
      ce = s.stop_at;
    end else begin
      ca = 0; cb = 0; ce = n;
      for (int k = cs; k < n && ce == n; k++) begin
        ba = st_va[k] && (s.len == 0 || ca < s.len);
        bb = st_vb[k] && (s.len == 0 || cb < s.len);
        e_ta[k] = ba && s.len != 0 && ca == s.len - 1;
        e_tb[k] = bb && s.len != 0 && cb == s.len - 1;
        if (ba) ca++;
        if (bb) cb++;
        e_or[k] = orc;
        if (st_or[k] != 2'b00 && orc < 255) orc++;
        if (k == s.stop_at || (s.len != 0 && ca == s.len && cb == s.len)) ce = k;
        if (ABORT && st_or[k] != 2'b00) begin ce = k; ab = 1'b1; end
      end
    end
    dn = ce + DRAIN_CYC + 1;

    for (int k = 0; k < n; k++) begin
      if (s.stop_at == 0 || k == 0) st = 0;
      else if (k <= ce)             st = (s.trig_en && k <= e) ? 1 : (k < cs) ? 2 : 3;
      else if (k <= ce + DRAIN_CYC) st = 4;
      else if (k == dn)             st = 5;
      else                          st = 0;
      e_state[k] = st;
      if (k == 0 || s.stop_at == 0) e_or[k] = model_or;
      else if (k > ce)              e_or[k] = orc;
      e_err[k] = (k == 0 || s.stop_at == 0) ? model_err : (k > ce) ? ab : 1'b0;
      if (s.rst_at >= 0 && k > s.rst_at) begin
        e_state[k] = 0; e_or[k] = 0; e_err[k] = 1'b0; e_ta[k] = 1'b0; e_tb[k] = 1'b0;
      end
    end

    if (s.rst_at >= 0)       n_run = s.rst_at + 5;
    else if (s.stop_at == 0) n_run = 6;
    else                     n_run = dn + 4;
    if (n_run > n) n_run = n;

    // Starts while busy and stops during DRAIN/DONE must both be ignored.
    if (s.stop_at != 0) begin
      for (int k = 1; k < n_run; k++) begin
        if (k <= dn && (s.rst_at < 0 || k < s.rst_at) && $urandom_range(9) == 0) st_start[k] = 1'b1;
        if (k > ce && k <= dn && $urandom_range(3) == 0) st_stop[k] = 1'b1;
      end
    end

    for (int k = 0; k < n_run; k++) begin
      @(posedge clk);
      #1;
      cfg_start       = st_start[k];
      cfg_stop        = st_stop[k];
      cfg_trig_ext_en = (k == 0) ? s.trig_en : 1'($urandom_range(1));
      cfg_length      = (k == 0) ? LEN_W'(s.len) : LEN_W'($urandom_range(5));
      cfg_delay       = (k == 0) ? DLY_W'(s.dly) : DLY_W'($urandom_range(5));
      ext_trig        = st_trig[k];
      s_tvalid_chA    = st_va[k];
      s_tvalid_chB    = st_vb[k];
      adc_or          = st_or[k];
      m_axi_aresetn   = (k != s.rst_at);
      @(negedge clk);
      cur_cyc = k;
      check("state",   32'(state_o),     32'(e_state[k]));
      check("en",      32'(ddr_data_en), 32'(e_state[k] == 3));
      check("busy",    32'(busy),        32'(e_state[k] != 0));
      check("done",    32'(done),        32'(e_state[k] == 5));
      check("tlastA",  32'(m_tlast_chA), 32'(e_ta[k]));
      check("tlastB",  32'(m_tlast_chB), 32'(e_tb[k]));
      check("or_evts", 32'(or_events),   32'(e_or[k]));
`ifdef ADC_CAPTURE_OR_ABORT_EN
      check("err_or",  32'(err_or),      32'(e_err[k]));
`endif
    end

    if (s.rst_at >= 0) begin
      model_or  = 0;
      model_err = 1'b0;
    end else if (s.stop_at != 0) begin
      model_or  = orc;
      model_err = ab;
    end
    m_axi_aresetn = 1'b1;
    cfg_start     = 1'b0;
    cfg_stop      = 1'b0;
  endtask

  initial begin
    scen_t s;
    m_axi_aresetn   = 1'b0;
    cfg_start       = 1'b1;
    cfg_stop        = 1'b0;
    cfg_trig_ext_en = 1'b0;
    ext_trig        = 1'b1;
    cfg_delay       = '0;
    cfg_length      = 16'd4;
    s_tvalid_chA    = 1'b1;
    s_tvalid_chB    = 1'b1;
    adc_or          = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state_o),     32'd0);
    check("rst_en",    32'(ddr_data_en), 32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_done",  32'(done),        32'd0);
    check("rst_tlast", 32'({m_tlast_chA, m_tlast_chB}), 32'd0);
    check("rst_or",    32'(or_events),   32'd0);
    @(posedge clk);
    #1;
    m_axi_aresetn = 1'b1;
    cfg_start     = 1'b0;
    adc_or        = 2'b00;

    s = dflt(); s.maxn = 30;
    run_scen("t1_len4", s);

    s = dflt(); s.len = 5; s.dly = 10; s.trig_en = 1'b1;
    s.trig_pre = 1'b1; s.trig_lo = 4; s.trig_hi = 9; s.maxn = 60;
    run_scen("t2_trig", s);

    s = dflt(); s.len = 3; s.pb = 15; s.stop_at = 250; s.maxn = 270;
    run_scen("t4_chA_only", s);

    s = dflt(); s.len = 0; s.p_or = 100; s.or_fix = 2'b01; s.stop_at = 301; s.maxn = 320;
    run_scen("t5_overrange", s);

    for (int i = 0; i < 14; i++) begin
      s = dflt();
      s.len      = ($urandom_range(4) == 0) ? 0 : int'($urandom_range(8, 1));
      s.dly      = $urandom_range(5);
      s.trig_en  = 1'($urandom_range(1));
      s.trig_pre = 1'($urandom_range(1));
      s.trig_lo  = $urandom_range(6, 2);
      s.trig_hi  = s.trig_lo + int'($urandom_range(8, 1));
      s.pa       = $urandom_range(100, 20);
      s.pb       = $urandom_range(100, 20);
      s.p_or     = ($urandom_range(3) == 0) ? int'($urandom_range(15)) : 0;
      s.stop_at  = $urandom_range(150, 1);
      s.maxn     = 200;
      run_scen("random", s);
    end

    s = dflt(); s.len = 0; s.dly = 2; s.stop_at = 66004; s.maxn = 66020;
    run_scen("t3_continuous", s);

    s = dflt(); s.len = 20; s.dly = 1; s.rst_at = 8; s.maxn = 30;
    run_scen("t6_reset", s);

    s = dflt(); s.stop_at = 0; s.maxn = 10;
    run_scen("t6_start_stop", s);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
